// File: rtl/cache_ctrl_wt_if.sv
// Processor/memory-side bus of the write-through cache controller.
// The controller takes the slave modport; the requester side takes master.
interface cache_ctrl_wt_if #(
  parameter int ADDR_W   = 10,
  parameter int OFFSET_W = 2
);
  logic                mem_read;
  logic                mem_write;
  logic                flush;
  logic [ADDR_W-1:0]   addr;
  logic                mem_ready;
  logic                stall;
  logic                hit;
  logic                cache_write;
  logic                cache_fill;
  logic [OFFSET_W-1:0] fill_offset;
  logic                main_read;
  logic                main_write;
  logic [ADDR_W-1:0]   main_addr;

  modport slave (
    input  mem_read, mem_write, flush,
    input  addr, mem_ready,
    output stall, hit, cache_write,
    output cache_fill, fill_offset,
    output main_read, main_write, main_addr
  );

  modport master (
    output mem_read, mem_write, flush,
    output addr, mem_ready,
    input  stall, hit, cache_write,
    input  cache_fill, fill_offset,
    input  main_read, main_write, main_addr
  );
endinterface

// File: rtl/cache_ctrl_wt.sv
// Direct-mapped write-through/no-allocate cache controller, falling-edge state.
// Define CACHE_PERF_CNT_EN to add saturating read-hit/miss/write counters.
module cache_ctrl_wt #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input logic clk,
  input logic rst,
  cache_ctrl_wt_if.slave bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [15:0] rd_hits,
  output logic [15:0] rd_misses,
  output logic [15:0] wr_count
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [OFFSET_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE, FILL, WRITE, FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [TAG_W-1:0]    tag_d [LINES];
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   req_q, req_d;
  logic                wr_hit_q, wr_hit_d;
  logic                wr_first_q, wr_first_d;

  logic [TAG_W-1:0]    a_tag, r_tag;
  logic [INDEX_W-1:0]  a_idx, r_idx;
  logic                hit, idle, go_flush;
  logic                go_fill, go_wr, fill_done;

  assign a_tag = bus.addr[ADDR_W-1 -: TAG_W];
  assign a_idx = bus.addr[OFFSET_W +: INDEX_W];
  assign r_tag = req_q[ADDR_W-1 -: TAG_W];
  assign r_idx = req_q[OFFSET_W +: INDEX_W];

  assign hit     = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign bus.hit = hit;

  assign idle      = (state_q == IDLE);
  assign go_flush  = idle && bus.flush;
  assign go_fill   = idle && !bus.flush && bus.mem_read && !hit;
  assign go_wr     = idle && !bus.flush && !bus.mem_read && bus.mem_write;
  assign fill_done = (state_q == FILL) && bus.mem_ready && (cnt_q == CNT_MAX);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_flush)     state_d = FLUSH;
        else if (go_fill) state_d = FILL;
        else if (go_wr)   state_d = WRITE;
      end
      FILL:    if (fill_done) state_d = IDLE;
      WRITE:   if (bus.mem_ready) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall       = 1'b0;
    bus.cache_write = 1'b0;
    bus.cache_fill  = 1'b0;
    bus.fill_offset = '0;
    bus.main_read   = 1'b0;
    bus.main_write  = 1'b0;
    bus.main_addr   = '0;
    case (state_q)
      IDLE: begin
        bus.stall = bus.flush
                  | (bus.mem_read & ~hit)
                  | bus.mem_write;
      end
      FILL: begin
        bus.stall       = 1'b1;
        bus.main_read   = 1'b1;
        bus.main_addr   = {req_q[ADDR_W-1:OFFSET_W], cnt_q};
        bus.fill_offset = cnt_q;
        bus.cache_fill  = bus.mem_ready;
      end
      WRITE: begin
        bus.stall       = 1'b1;
        bus.main_write  = 1'b1;
        bus.main_addr   = req_q;
        bus.cache_write = wr_first_q & wr_hit_q;
      end
      default: bus.stall = 1'b1;
    endcase
  end

  // Line is invalidated at fill start so a reset or abort leaves it unusable.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    wr_hit_d   = wr_hit_q;
    wr_first_d = 1'b0;
    if (go_flush) valid_d = '0;
    if (go_fill) begin
      req_d          = bus.addr;
      valid_d[a_idx] = 1'b0;
      cnt_d          = '0;
    end
    if (go_wr) begin
      req_d      = bus.addr;
      wr_hit_d   = hit;
      wr_first_d = 1'b1;
    end
    if (state_q == FILL && bus.mem_ready) begin
      cnt_d = cnt_q + OFFSET_W'(1);
      if (cnt_q == CNT_MAX) begin
        valid_d[r_idx] = 1'b1;
        tag_d[r_idx]   = r_tag;
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      cnt_q      <= '0;
      req_q      <= '0;
      wr_hit_q   <= 1'b0;
      wr_first_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      wr_hit_q   <= wr_hit_d;
      wr_first_q <= wr_first_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        rd_hit_acc;
  logic [15:0] rd_hits_q, rd_misses_q, wr_count_q;

  assign rd_hit_acc = idle && !bus.flush && bus.mem_read && hit;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rd_hits_q   <= '0;
      rd_misses_q <= '0;
      wr_count_q  <= '0;
    end else begin
      if (rd_hit_acc && rd_hits_q != 16'hFFFF)
        rd_hits_q <= rd_hits_q + 16'd1;
      if (go_fill && rd_misses_q != 16'hFFFF)
        rd_misses_q <= rd_misses_q + 16'd1;
      if (go_wr && wr_count_q != 16'hFFFF)
        wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign rd_hits   = rd_hits_q;
  assign rd_misses = rd_misses_q;
  assign wr_count  = wr_count_q;
`endif
endmodule
